// File: rtl/log2_lut_arbiter.sv
// log2_lut_arbiter: round-robin share of one log2 fraction LUT behind a
// 2-stage valid/ready pipe. Each result carries its requester ID.
// Ports: clock, resetN (async, active-low); req_valid/req_data/req_ready
// per requester (lane i at req_data[i*IN_W +: IN_W]); out_valid/out_data/
// out_id/out_ready downstream.
// Optional: define LOG2_LUT_ARBITER_STATS_EN to add stat_grants (16 bits
// per requester) and stat_stall, saturating counters.
module log2_lut_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int IN_W    = 8,
  parameter int OUT_W   = 5
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    out_valid,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id,
`ifdef LOG2_LUT_ARBITER_STATS_EN
  output logic [NUM_REQ*16-1:0]   stat_grants,
  output logic [15:0]             stat_stall,
`endif
  input  logic                    out_ready
);

  // Code k is reached once x clears the round-to-nearest point
  // 256*(2^((k-0.5)/16)-1); counting cleared thresholds gives a
  // monotonic map that tops out at 16.
  localparam logic [7:0] THR [16] = '{
    8'd6,   8'd18,  8'd30,  8'd42,
    8'd56,  8'd69,  8'd84,  8'd99,
    8'd114, 8'd131, 8'd148, 8'd166,
    8'd184, 8'd204, 8'd224, 8'd246
  };

  function automatic logic [OUT_W-1:0] lut(
    input logic [IN_W-1:0] x
  );
    logic [OUT_W-1:0] n;
    n = '0;
    for (int k = 0; k < 16; k++) begin
      if (x >= THR[k]) n = n + OUT_W'(1);
    end
    return n;
  endfunction

  logic              s1_valid;
  logic [IN_W-1:0]   s1_data;
  logic [ID_W-1:0]   s1_id;
  logic [ID_W-1:0]   rr_ptr;
  logic              s1_adv;
  logic              s2_adv;

  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] hs_vec;
  logic               hs;
  logic [ID_W-1:0]    gnt_id;
  logic [IN_W-1:0]    sel_data;
  logic [ID_W:0]      idx;
  logic               found;

  assign s2_adv = !out_valid | out_ready;
  assign s1_adv = !s1_valid | s2_adv;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        gnt[idx[ID_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  assign req_ready = gnt & {NUM_REQ{s1_adv}};
  assign hs_vec    = req_valid & req_ready;
  assign hs        = |hs_vec;

  always_comb begin
    gnt_id   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) gnt_id = ID_W'(i);
      sel_data = sel_data |
        (req_data[i*IN_W +: IN_W] & {IN_W{gnt[i]}});
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
      rr_ptr   <= ID_W'(NUM_REQ-1);
    end else if (hs) begin
      s1_valid <= 1'b1;
      s1_data  <= sel_data;
      s1_id    <= gnt_id;
      rr_ptr   <= gnt_id;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      out_data  <= lut(s1_data);
      out_id    <= s1_id;
    end
  end

`ifdef LOG2_LUT_ARBITER_STATS_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs_vec[i] &&
            stat_grants[i*16 +: 16] != 16'hFFFF)
          stat_grants[i*16 +: 16] <=
            stat_grants[i*16 +: 16] + 16'd1;
      end
      if (out_valid && !out_ready &&
          stat_stall != 16'hFFFF)
        stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_log2_lut_arbiter.sv
// tb_log2_lut_arbiter: random and directed stimulus vs a queue-based
// reference of the arbiter, pipe and log2 rounding rule.
module tb_log2_lut_arbiter;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           resetN;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [4:0]     out_data;
  logic [1:0]     out_id;
  logic           out_ready;
`ifdef LOG2_LUT_ARBITER_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_stall;
`endif

  log2_lut_arbiter #(.NUM_REQ(N)) dut (
    .clock(clock),
    .resetN(resetN),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_id(out_id),
`ifdef LOG2_LUT_ARBITER_STATS_EN
    .stat_grants(stat_grants),
    .stat_stall(stat_stall),
`endif
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  bit       pend [N];
  bit [7:0] pdata [N];

  int last_gnt;
  int qd [$];
  int qi [$];
  int qa [$];
  int gcnt [N];
  int scnt;

  int           winner;
  logic [N-1:0] exp_ready;
  bit           exp_ov;
  int           exp_od;
  int           exp_oid;

  function automatic int ref_lut(input int x);
    real v;
    int  r;
    v = 16.0 * $ln(1.0 + x / 256.0) / $ln(2.0);
    r = $rtoi(v + 0.5);
    if (r > 16) r = 16;
    return r;
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i];
      req_data[i*8 +: 8] = pdata[i];
    end
  endtask

  task automatic model_reset();
    qd.delete(); qi.delete(); qa.delete();
    last_gnt = N - 1;
    scnt = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; gcnt[i] = 0;
    end
  endtask

  // Up to two items in flight; an item is visible once it has
  // seen two edges and is at the head of the queue.
  task automatic model_eval();
    bit acc;
    winner = -1;
    for (int off = 1; off <= N; off++) begin
      int i;
      i = (last_gnt + off) % N;
      if (winner < 0 && pend[i]) winner = i;
    end
    acc = (qd.size() < 2) || out_ready;
    exp_ready = (winner >= 0 && acc) ?
      (N'(1) << winner) : '0;
    exp_ov  = qd.size() > 0 && qa[0] >= 2;
    exp_od  = exp_ov ? qd[0] : 0;
    exp_oid = exp_ov ? qi[0] : 0;
  endtask

  task automatic model_commit();
    if (exp_ov && !out_ready && scnt < 65535) scnt++;
    if (exp_ov && out_ready) begin
      void'(qd.pop_front());
      void'(qi.pop_front());
      void'(qa.pop_front());
    end
    for (int j = 0; j < qa.size(); j++) qa[j]++;
    if (exp_ready != 0) begin
      qd.push_back(ref_lut(pdata[winner]));
      qi.push_back(winner);
      qa.push_back(1);
      last_gnt = winner;
      pend[winner] = 0;
      if (gcnt[winner] < 65535) gcnt[winner]++;
    end
  endtask

  task automatic test_reset();
    model_reset();
    out_ready = 1'b1;
    resetN = 1'b0;
    apply();
    #12;
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 5'd0 ||
        out_id !== 2'd0 || req_ready !== 4'd0) begin
      nerr++;
      $display("FAIL reset: v=%b d=%0d id=%0d rdy=%b want 0",
        out_valid, out_data, out_id, req_ready);
    end
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single();
    int ov_n = 0;
    int ov_k = -1;
    pend[2] = 1; pdata[2] = 8'h80;
    for (int k = 0; k < 6; k++) begin
      apply();
      @(negedge clock);
      model_eval();
      nvec++;
      if (req_ready !== exp_ready) begin
        nerr++;
        $display("FAIL single rdy: got %b want %b",
          req_ready, exp_ready);
      end
      if (out_valid) begin ov_n++; ov_k = k; end
      if (out_valid && (out_data !== 5'd9 || out_id !== 2'd2)) begin
        nerr++;
        $display("FAIL single out: got d=%0d id=%0d want 9/2",
          out_data, out_id);
      end
      @(posedge clock);
      model_commit();
      #1;
    end
    nvec++;
    if (ov_n != 1 || ov_k != 2) begin
      nerr++;
      $display("FAIL single lat: got n=%0d at %0d want 1 at 2",
        ov_n, ov_k);
    end
  endtask

  task automatic test_sweep();
    int nxt = 0;
    int rc = 0;
    int first = -1;
    int last = -1;
    out_ready = 1'b1;
    for (int k = 0; k < 270 && rc < 256; k++) begin
      if (!pend[0] && nxt < 256) begin
        pend[0] = 1; pdata[0] = 8'(nxt); nxt++;
      end
      apply();
      @(negedge clock);
      model_eval();
      nvec++;
      if (req_ready !== exp_ready || out_valid !== exp_ov) begin
        nerr++;
        $display("FAIL sweep ctl: rdy=%b v=%b want %b %b",
          req_ready, out_valid, exp_ready, exp_ov);
      end
      if (out_valid) begin
        nvec++;
        if (out_data !== 5'(ref_lut(rc)) || out_id !== 2'd0) begin
          nerr++;
          $display("FAIL sweep x=%0d: got %0d/%0d want %0d/0",
            rc, out_data, out_id, ref_lut(rc));
        end
        if (first < 0) first = k;
        last = k;
        rc++;
      end
      @(posedge clock);
      model_commit();
      #1;
    end
    nvec++;
    if (rc != 256 || last - first != 255) begin
      nerr++;
      $display("FAIL sweep count: got %0d in %0d cyc want 256/255",
        rc, last - first);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < N; i++) pend[i] = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      apply();
      @(negedge clock);
      model_eval();
      nvec++;
      if (out_valid !== exp_ov ||
          (exp_ov && (out_data !== 5'(exp_od) ||
                      out_id !== 2'(exp_oid)))) begin
        nerr++;
        $display("FAIL drain: got v=%b %0d/%0d want %b %0d/%0d",
          out_valid, out_data, out_id, exp_ov, exp_od, exp_oid);
      end
      @(posedge clock);
      model_commit();
      #1;
    end
  endtask

  task automatic test_round_robin();
    int dtab [N] = '{1, 2, 12, 16};
    bit [7:0] itab [N] = '{8'h06, 8'h12, 8'hA6, 8'hFF};
    int rc = 0;
    int start;
    int seen [N] = '{0, 0, 0, 0};
    start = (last_gnt + 1) % N;
    out_ready = 1'b1;
    for (int k = 0; k < 26; k++) begin
      for (int i = 0; i < N; i++) begin
        pend[i] = 1; pdata[i] = itab[i];
      end
      apply();
      @(negedge clock);
      model_eval();
      nvec++;
      if (req_ready !== exp_ready) begin
        nerr++;
        $display("FAIL rr rdy: got %b want %b", req_ready, exp_ready);
      end
      if (out_valid) begin
        int eid;
        eid = (start + rc) % N;
        nvec++;
        if (out_id !== 2'(eid) || out_data !== 5'(dtab[eid])) begin
          nerr++;
          $display("FAIL rr seq %0d: got %0d/%0d want %0d/%0d",
            rc, out_id, out_data, eid, dtab[eid]);
        end
        seen[out_id]++;
        rc++;
      end
      @(posedge clock);
      model_commit();
      #1;
    end
    for (int i = 0; i < N; i++) begin
      nvec++;
      if (seen[i] < 5) begin
        nerr++;
        $display("FAIL rr starve %0d: got %0d grants want >=5",
          i, seen[i]);
      end
    end
    test_drain();
  endtask

  task automatic test_backpressure();
    int acc_stall = 0;
    logic [4:0] hd;
    logic [1:0] hi;
    bit held = 0;
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin pend[i] = 1; pdata[i] = 8'($urandom); end
      out_ready = !(k >= 6 && k < 11);
      apply();
      @(negedge clock);
      model_eval();
      nvec++;
      if (req_ready !== exp_ready || out_valid !== exp_ov ||
          (exp_ov && (out_data !== 5'(exp_od) ||
                      out_id !== 2'(exp_oid)))) begin
        nerr++;
        $display("FAIL bp %0d: rdy=%b v=%b %0d/%0d want %b %b %0d/%0d",
          k, req_ready, out_valid, out_data, out_id,
          exp_ready, exp_ov, exp_od, exp_oid);
      end
      if (!out_ready) begin
        if (req_ready != 0) acc_stall++;
        if (held) begin
          nvec++;
          if (out_data !== hd || out_id !== hi) begin
            nerr++;
            $display("FAIL bp hold: got %0d/%0d want %0d/%0d",
              out_data, out_id, hd, hi);
          end
        end
        hd = out_data; hi = out_id; held = out_valid;
      end
      @(posedge clock);
      model_commit();
      #1;
    end
    nvec++;
    if (acc_stall > 2) begin
      nerr++;
      $display("FAIL bp accepts: got %0d want <=2", acc_stall);
    end
    test_drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 99) < 40) begin
          pend[i] = 1; pdata[i] = 8'($urandom);
        end
      out_ready = $urandom_range(0, 99) < 70;
      apply();
      @(negedge clock);
      model_eval();
      nvec++;
      if (req_ready !== exp_ready || out_valid !== exp_ov ||
          (exp_ov && (out_data !== 5'(exp_od) ||
                      out_id !== 2'(exp_oid)))) begin
        nerr++;
        $display("FAIL rand %0d: rdy=%b v=%b %0d/%0d want %b %b %0d/%0d",
          k, req_ready, out_valid, out_data, out_id,
          exp_ready, exp_ov, exp_od, exp_oid);
      end
      @(posedge clock);
      model_commit();
      #1;
    end
    test_drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin pend[i] = 1; pdata[i] = 8'($urandom); end
      apply();
      @(posedge clock);
      model_eval();
      model_commit();
      #1;
    end
    @(negedge clock);
    #2;
    resetN = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL areset: out_valid=%b want 0", out_valid);
    end
    model_reset();
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1; pdata[i] = 8'(i * 40);
    end
    apply();
    #1;
    nvec++;
    if (req_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL areset gnt: got %b want 0001", req_ready);
    end
    @(posedge clock);
    model_eval();
    model_commit();
    #1;
    test_drain();
  endtask

`ifdef LOG2_LUT_ARBITER_STATS_EN
  task automatic test_stats();
    out_ready = 1'b1;
    for (int k = 0; k < 70010; k++) begin
      if (!pend[1]) begin pend[1] = 1; pdata[1] = 8'($urandom); end
      apply();
      @(negedge clock);
      model_eval();
      @(posedge clock);
      model_commit();
      #1;
    end
    test_drain();
    nvec++;
    if (stat_grants[16 +: 16] !== 16'hFFFF ||
        stat_grants[0 +: 16] !== 16'(gcnt[0])) begin
      nerr++;
      $display("FAIL stat_grants: got %h/%h want ffff/%h",
        stat_grants[16 +: 16], stat_grants[0 +: 16], gcnt[0]);
    end
    nvec++;
    if (stat_stall !== 16'(scnt)) begin
      nerr++;
      $display("FAIL stat_stall: got %0d want %0d", stat_stall, scnt);
    end
  endtask
`endif

  initial begin
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_drain();
    test_sweep();
    test_drain();
    test_round_robin();
    test_backpressure();
    test_random();
    test_async_reset();
    test_random();
`ifdef LOG2_LUT_ARBITER_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
